// File: rtl/game_pixel_renderer.sv
// Pong-style pixel source: per-frame ball/paddle game state plus a registered RGB lookup per raster pixel.
// Optional AUTOPILOT_EN: paddle tracks the ball and the buttons are ignored.
module game_pixel_renderer #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_W     = 64,
    parameter int PADDLE_H     = 8,
    parameter int PADDLE_Y     = 456,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_SPEED = 4,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       pixel_valid,
    input  logic       frame_start,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic [7:0] score,
    output logic [1:0] game_state
);
    typedef enum logic [1:0] {ST_SERVE = 2'b00, ST_PLAY = 2'b01, ST_MISS = 2'b10} state_t;

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
    localparam logic [9:0] BALL_X0 = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_Y0 = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] PAD_X0  = 10'((H_ACTIVE - PADDLE_W) / 2);
    localparam logic [9:0] X_MAX_U = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [9:0] Y_MAX_U = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0] Y_HIT_U = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic signed [11:0] S_BSPD = 12'(BALL_SPEED);
    localparam logic signed [11:0] S_PSPD = 12'(PADDLE_SPEED);
    localparam logic signed [11:0] S_BSZ  = 12'(BALL_SIZE);
    localparam logic signed [11:0] S_PW   = 12'(PADDLE_W);
    localparam logic signed [11:0] S_PY   = 12'(PADDLE_Y);
    localparam logic signed [11:0] S_XMAX = 12'(H_ACTIVE - BALL_SIZE);
    localparam logic signed [11:0] S_YMAX = 12'(V_ACTIVE - BALL_SIZE);
    localparam logic signed [11:0] S_PMAX = 12'(H_ACTIVE - PADDLE_W);

    state_t           r_state;
    logic [CNT_W-1:0] r_serve_cnt;
    logic [9:0]       r_ball_x, r_ball_y, r_paddle_x;
    logic             r_dx, r_dy;
    logic [7:0]       r_score;

    assign score      = r_score;
    assign game_state = r_state;

    // Render: 11-bit unsigned compares so box right/bottom edges never wrap.
    logic [10:0] w_px, w_py, w_bx11, w_by11, w_pad11;
    logic        w_in_ball, w_in_pad;
    assign w_px      = {1'b0, pixel_x};
    assign w_py      = {1'b0, pixel_y};
    assign w_bx11    = {1'b0, r_ball_x};
    assign w_by11    = {1'b0, r_ball_y};
    assign w_pad11   = {1'b0, r_paddle_x};
    assign w_in_ball = (w_px >= w_bx11) && (w_px < w_bx11 + 11'(BALL_SIZE)) &&
                       (w_py >= w_by11) && (w_py < w_by11 + 11'(BALL_SIZE));
    assign w_in_pad  = (w_px >= w_pad11) && (w_px < w_pad11 + 11'(PADDLE_W)) &&
                       (w_py >= 11'(PADDLE_Y)) && (w_py < 11'(PADDLE_Y + PADDLE_H));

    always_ff @(posedge clk) begin
        if (!reset)               {red, green, blue} <= '0;
        else if (!pixel_valid)    {red, green, blue} <= '0;
        else if (w_in_ball)       {red, green, blue} <= 24'hFFFFFF;
        else if (w_in_pad)        {red, green, blue} <= 24'h00FF00;
        else                      {red, green, blue} <= 24'h000040;
    end

    // Signed 12-bit game arithmetic so steps past the left/top edge go negative.
    logic signed [11:0] w_bx, w_by, w_pad, w_nx, w_ny, w_pad_nxt;
    logic               w_hit;
    assign w_bx  = $signed({2'b00, r_ball_x});
    assign w_by  = $signed({2'b00, r_ball_y});
    assign w_pad = $signed({2'b00, r_paddle_x});
    assign w_nx  = w_bx + (r_dx ? S_BSPD : -S_BSPD);
    assign w_ny  = w_by + (r_dy ? S_BSPD : -S_BSPD);
    assign w_hit = r_dy && (w_by + S_BSZ <= S_PY) && (w_ny + S_BSZ >= S_PY) &&
                   (w_bx + S_BSZ > w_pad) && (w_bx < w_pad + S_PW);

`ifdef AUTOPILOT_EN
    logic signed [11:0] w_target_raw, w_target, w_diff;
    logic               w_unused_btns;
    assign w_unused_btns = btn_left ^ btn_right;
    assign w_target_raw  = w_bx + 12'(BALL_SIZE / 2) - 12'(PADDLE_W / 2);
    assign w_target      = (w_target_raw < 12'sd0) ? 12'sd0 :
                           (w_target_raw > S_PMAX) ? S_PMAX : w_target_raw;
    assign w_diff        = w_target - w_pad;
    always_comb begin
        w_pad_nxt = w_pad;
        if ((w_diff < S_PSPD) && (w_diff > -S_PSPD)) w_pad_nxt = w_target;
        else if (w_diff > 12'sd0)                     w_pad_nxt = w_pad + S_PSPD;
        else                                          w_pad_nxt = w_pad - S_PSPD;
    end
`else
    logic signed [11:0] w_step_l, w_step_r;
    assign w_step_l = w_pad - S_PSPD;
    assign w_step_r = w_pad + S_PSPD;
    always_comb begin
        w_pad_nxt = w_pad;
        if (btn_left && !btn_right)      w_pad_nxt = (w_step_l < 12'sd0) ? 12'sd0 : w_step_l;
        else if (btn_right && !btn_left) w_pad_nxt = (w_step_r > S_PMAX) ? S_PMAX : w_step_r;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_SERVE;
            r_serve_cnt <= '0;
            r_ball_x    <= BALL_X0;
            r_ball_y    <= BALL_Y0;
            r_dx        <= 1'b1;
            r_dy        <= 1'b1;
            r_paddle_x  <= PAD_X0;
            r_score     <= '0;
        end else if (frame_start) begin
            r_paddle_x <= w_pad_nxt[9:0];
            case (r_state)
                ST_SERVE: begin
                    if (r_serve_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
                        r_state     <= ST_PLAY;
                        r_serve_cnt <= '0;
                    end else begin
                        r_serve_cnt <= r_serve_cnt + CNT_W'(1);
                    end
                end
                ST_PLAY: begin
                    if (w_nx < 12'sd0) begin
                        r_ball_x <= '0;
                        r_dx     <= 1'b1;
                    end else if (w_nx > S_XMAX) begin
                        r_ball_x <= X_MAX_U;
                        r_dx     <= 1'b0;
                    end else begin
                        r_ball_x <= w_nx[9:0];
                    end
                    if (!r_dy) begin
                        if (w_ny < 12'sd0) begin
                            r_ball_y <= '0;
                            r_dy     <= 1'b1;
                        end else begin
                            r_ball_y <= w_ny[9:0];
                        end
                    end else if (w_hit) begin
                        r_ball_y <= Y_HIT_U;
                        r_dy     <= 1'b0;
                        if (r_score != 8'hFF) r_score <= r_score + 8'd1;
                    end else if (w_ny >= S_YMAX) begin
                        r_ball_y <= Y_MAX_U;
                        r_state  <= ST_MISS;
                    end else begin
                        r_ball_y <= w_ny[9:0];
                    end
                end
                default: begin
                    r_state     <= ST_SERVE;
                    r_serve_cnt <= '0;
                    r_ball_x    <= BALL_X0;
                    r_ball_y    <= BALL_Y0;
                    r_dx        <= 1'b1;
                    r_dy        <= 1'b1;
                    r_score     <= '0;
                end
            endcase
        end
    end
endmodule
